par_rw_circular_buffer: RTL and testbench
=========================================

// Module: par_rw_circular_buffer
// PURPOSE
//   Parametrised multi-word circular FIFO for the CNN PE data path (filter, IFmap and psum buffers).
//   Accepts PAR_WRITE words per push and delivers PAR_READ words per pop, with PAR_WRITE and PAR_READ independent.
//   DEPTH may be any value, not only a power of two.
//   Provides a valid/ready handshake on both sides, an occupancy count and a synchronous flush.
// PARAMETERS
//   WIDTH      16  bits per word
//   DEPTH      12  storage words; must satisfy DEPTH >= max(PAR_WRITE, PAR_READ)
//   PAR_WRITE   3  words accepted per push
//   PAR_READ    2  words delivered per pop
//   AF_LEVEL   10  almost_full threshold, in words (ALMOST_FLAGS_EN only)
//   AE_LEVEL    2  almost_empty threshold, in words (ALMOST_FLAGS_EN only)
//   AW = $clog2(DEPTH), CW = $clog2(DEPTH+1) (localparams)
// PORTS
//   clk           in   1               rising-edge clock
//   rst           in   1               synchronous reset, active-low
//   flush         in   1               synchronous clear of pointers and count
//   din_valid     in   1               push request
//   din           in   WIDTH*PAR_WRITE write words; bits [0:WIDTH-1] = oldest word
//   din_ready     out  1               free space >= PAR_WRITE
//   dout          out  WIDTH*PAR_READ  read words; bits [0:WIDTH-1] = oldest word
//   dout_valid    out  1               count >= PAR_READ
//   dout_ready    in   1               pop request
//   count         out  CW              words currently stored
//   almost_full   out  1               count >= AF_LEVEL (ALMOST_FLAGS_EN only)
//   almost_empty  out  1               count <= AE_LEVEL (ALMOST_FLAGS_EN only)
// BEHAVIOUR
// - State: memory [0:DEPTH-1], wptr and rptr (AW bits each), cnt (CW bits).
//   cnt is the only source of full/empty, so there is no pointer-equality ambiguity.
// - Reset (rst==0 at a clock edge): wptr=0, rptr=0, cnt=0.
//   Resulting outputs: count=0, dout_valid=0, din_ready=1, almost_empty=1, almost_full=0.
//   Memory contents are not reset. Reset overrides every other input in that cycle.
// - din_ready = (DEPTH-cnt >= PAR_WRITE); dout_valid = (cnt >= PAR_READ).
//   Both are combinational from registered state only.
//   A pop in the same cycle does not raise din_ready (no pass-through path).
// - Push fires when din_valid && din_ready.
//   Word i is written to mem[(wptr+i) mod DEPTH]; then wptr <= (wptr+PAR_WRITE) mod DEPTH.
// - Pop fires when dout_valid && dout_ready.
//   rptr <= (rptr+PAR_READ) mod DEPTH.
// - dout is show-ahead: word j = mem[(rptr+j) mod DEPTH], combinational from memory and rptr.
//   dout is don't-care while dout_valid=0.
// - Modulo wrap is an explicit compare-and-subtract, so non-power-of-two DEPTH wraps correctly.
// - Push and pop in the same cycle: cnt <= cnt + PAR_WRITE - PAR_READ.
//   The read and write address ranges never overlap, because the push is gated by free space.
// - Push without a handshake (din_valid && !din_ready) is ignored. Nothing is stored and this is not an error.
// - Pop without a handshake (dout_ready && !dout_valid) is ignored.
// - flush==1 (with rst==1): wptr=rptr=cnt=0 on the next edge.
//   A push or pop presented in the same cycle is dropped.
// - Latency: pushed words are visible on dout the cycle after the push edge, provided cnt reaches PAR_READ.
// CONFIGURATION
//   ALMOST_FLAGS_EN defined:
//     almost_full and almost_empty ports exist.
//     They are combinational from cnt, using the thresholds AF_LEVEL and AE_LEVEL.
//   ALMOST_FLAGS_EN undefined:
//     Both ports and their logic are absent.
//     AF_LEVEL and AE_LEVEL are unused. All other behaviour is identical.
// TESTING (defaults; push k carries words 3k-2..3k)
//   1 Reset: hold rst=0 for 1 edge with din_valid=1
//     -> count=0, dout_valid=0, din_ready=1; nothing is stored.
//   2 Fill: four pushes of words 1..12
//     -> count=12, din_ready=0, dout={1,2}; a fifth push attempt leaves count=12.
//   3 Drain: six pops
//     -> dout sequence {1,2},{3,4},...,{11,12}; count=0, dout_valid=0; a 7th pop attempt is ignored.
//   4 Wrap: fill to 12, then 2 pops (count=8), then a push of 13..15
//     -> the words land at addr 0..2, count=11, din_ready=0.
//     -> subsequent pops return 5..14 in order; the last word, 15, is left with count=1 and dout_valid=0.
//   5 Simultaneous: at count=6, push and pop on the same edge
//     -> count=7, data order preserved.
//     -> at count=10, push and pop together: push blocked, pop accepted, count=8.
//   6 Flush: at count=9, flush=1 together with din_valid=1
//     -> count=0, dout_valid=0; the flushed push is not stored.
//     -> with ALMOST_FLAGS_EN: almost_empty=1, almost_full=0.

Source files
------------

// File: rtl/par_rw_circular_buffer.sv
// -----------------------------------------------------------------------------
// par_rw_circular_buffer
//   Multi-word circular FIFO for the CNN PE data path (filter, IFmap and psum
//   buffers). Each push stores PAR_WRITE words and each pop removes PAR_READ
//   words. The two widths are independent, and DEPTH does not need to be a
//   power of two. A single occupancy counter is the only source of full/empty
//   state, so wptr == rptr never has to be interpreted.
//
//   Optional feature macro: ALMOST_FLAGS_EN
//     When it is defined, the almost_full and almost_empty ports exist.
//     When it is undefined, both ports and their logic are absent.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous reset, active-low (clears wptr, rptr, cnt)
//   flush         in   synchronous clear of pointers and count; drops push/pop
//   din_valid     in   push request
//   din           in   PAR_WRITE words; word 0 (oldest) in din[WIDTH-1:0]
//   din_ready     out  free space >= PAR_WRITE
//   dout          out  PAR_READ words, show-ahead; word 0 (oldest) in low bits
//   dout_valid    out  count >= PAR_READ
//   dout_ready    in   pop request
//   count         out  words currently stored
//   almost_full   out  count >= AF_LEVEL   (ALMOST_FLAGS_EN only)
//   almost_empty  out  count <= AE_LEVEL   (ALMOST_FLAGS_EN only)
// -----------------------------------------------------------------------------
module par_rw_circular_buffer #(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 12,
   parameter int PAR_WRITE = 3,
   parameter int PAR_READ  = 2,
   parameter int AF_LEVEL  = 10,
   parameter int AE_LEVEL  = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          din_valid,
   input  logic [WIDTH*PAR_WRITE-1:0]    din,
   output logic                          din_ready,
   output logic [WIDTH*PAR_READ-1:0]     dout,
   output logic                          dout_valid,
   input  logic                          dout_ready,
   output logic [$clog2(DEPTH+1)-1:0]    count
`ifdef ALMOST_FLAGS_EN
   ,
   output logic                          almost_full,
   output logic                          almost_empty
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] PW_C    = CW'(PAR_WRITE);
   localparam logic [CW-1:0] PR_C    = CW'(PAR_READ);
   localparam logic [AW:0]   DEPTH_A = (AW+1)'(DEPTH);
   localparam logic [AW:0]   PW_A    = (AW+1)'(PAR_WRITE);
   localparam logic [AW:0]   PR_A    = (AW+1)'(PAR_READ);

   // The stored word count and the threshold levels cannot be larger than the storage.
   if (DEPTH < PAR_WRITE || DEPTH < PAR_READ || AF_LEVEL > DEPTH || AE_LEVEL > DEPTH) begin : g_param_check
      $error("par_rw_circular_buffer: DEPTH must cover PAR_WRITE, PAR_READ and both almost levels");
   end

   // Adds an offset to a pointer modulo DEPTH. The pointer is < DEPTH and the
   // offset is <= DEPTH, so one conditional subtract is enough for any DEPTH.
   function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] base,
                                              input logic [AW:0]   off);
      logic [AW:0] sum;
      sum = {1'b0, base} + off;
      if (sum >= DEPTH_A) sum = sum - DEPTH_A;
      return sum[AW-1:0];
   endfunction

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [CW-1:0]    cnt;
   logic             push_fire;
   logic             pop_fire;
   logic             wr_en;

   // The handshakes depend only on registered state. A pop in the same cycle
   // does not make room for a push.
   assign din_ready  = (DEPTH_C - cnt) >= PW_C;
   assign dout_valid = cnt >= PR_C;
   assign push_fire  = din_valid && din_ready;
   assign pop_fire   = dout_ready && dout_valid;
   assign count      = cnt;

   // Reset and flush both drop a push that is presented in the same cycle, so
   // the memory never receives its words.
   assign wr_en = push_fire && rst && !flush;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < PAR_WRITE; i++) begin
            mem[wrap_add(wptr, (AW+1)'(i))] <= din[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push_fire) wptr <= wrap_add(wptr, PW_A);
         if (pop_fire)  rptr <= wrap_add(rptr, PR_A);
         // Push is gated by free space and pop is gated by occupancy, so the
         // counter stays in 0..DEPTH for every combination.
         unique case ({push_fire, pop_fire})
            2'b10:   cnt <= cnt + PW_C;
            2'b01:   cnt <= cnt - PR_C;
            2'b11:   cnt <= cnt + PW_C - PR_C;
            default: cnt <= cnt;
         endcase
      end
   end

   // Show-ahead read port: the oldest PAR_READ words are always presented.
   always_comb begin
      dout = '0;
      for (int j = 0; j < PAR_READ; j++) begin
         dout[j*WIDTH +: WIDTH] = mem[wrap_add(rptr, (AW+1)'(j))];
      end
   end

`ifdef ALMOST_FLAGS_EN
   assign almost_full  = cnt >= CW'(AF_LEVEL);
   assign almost_empty = cnt <= CW'(AE_LEVEL);
`endif

endmodule

// File: tb/tb_par_rw_circular_buffer.sv
// -----------------------------------------------------------------------------
// tb_par_rw_circular_buffer
//   Directed bench for par_rw_circular_buffer at the default parameters.
//   The driver issues directed vectors. When a push is expected to be
//   accepted, it appends the pushed words to a scoreboard queue. A separate
//   negedge monitor compares every popped pair against that queue, and it
//   checks the handshake flags and count against the queue size.
// -----------------------------------------------------------------------------
module tb_par_rw_circular_buffer;

   localparam int W  = 16;
   localparam int D  = 12;
   localparam int PW = 3;
   localparam int PR = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              din_valid;
   logic [W*PW-1:0]   din;
   logic              din_ready;
   logic [W*PR-1:0]   dout;
   logic              dout_valid;
   logic              dout_ready;
   logic [3:0]        count;
`ifdef ALMOST_FLAGS_EN
   logic              almost_full;
   logic              almost_empty;
`endif

   int checks   = 0;
   int failures = 0;
   int unsigned exp_q[$];

   always #5 clk = ~clk;

   par_rw_circular_buffer #(
      .WIDTH(W), .DEPTH(D), .PAR_WRITE(PW), .PAR_READ(PR), .AF_LEVEL(10), .AE_LEVEL(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .din_valid(din_valid),
      .din(din),
      .din_ready(din_ready),
      .dout(dout),
      .dout_valid(dout_valid),
      .dout_ready(dout_ready),
      .count(count)
`ifdef ALMOST_FLAGS_EN
      ,
      .almost_full(almost_full),
      .almost_empty(almost_empty)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic logic [W*PW-1:0] pack3(input int b);
      return {16'(b + 2), 16'(b + 1), 16'(b)};
   endfunction

   // One clock of stimulus. acc is the hand-derived expectation that the push
   // will be accepted; only then do its words enter the scoreboard.
   task automatic cycle(input bit v, input int base, input bit r, input bit fl, input bit acc);
      din_valid  = v;
      din        = pack3(base);
      dout_ready = r;
      flush      = fl;
      @(posedge clk);
      if (fl) exp_q.delete();
      if (acc) begin
         for (int i = 0; i < PW; i++) exp_q.push_back(base + i);
      end
      #1;
      din_valid  = 1'b0;
      dout_ready = 1'b0;
      flush      = 1'b0;
   endtask

   // Monitor: the state is stable at the negedge, before the edge that acts on it.
   always @(negedge clk) begin
      if (rst === 1'b1 && flush === 1'b0) begin
         check("mon_count", 32'(count), 32'(exp_q.size()));
         check("mon_dout_valid", 32'(dout_valid), 32'(exp_q.size() >= PR));
         check("mon_din_ready", 32'(din_ready), 32'((D - exp_q.size()) >= PW));
         if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
            if (exp_q.size() < PR) begin
               checks++;
               failures++;
               $display("FAIL mon_underflow actual=pop_with_%0d_words required=%0d", exp_q.size(), PR);
            end else begin
               int unsigned e0, e1;
               e0 = exp_q.pop_front();
               e1 = exp_q.pop_front();
               check("dout_word0", 32'(dout[15:0]), e0);
               check("dout_word1", 32'(dout[31:16]), e1);
            end
         end
      end
   end

   initial begin
      // 1 Reset with a push request held: nothing is stored.
      rst        = 1'b0;
      flush      = 1'b0;
      din_valid  = 1'b1;
      din        = pack3(1);
      dout_ready = 1'b0;
      @(posedge clk);
      #1;
      rst       = 1'b1;
      din_valid = 1'b0;
      check("reset_count", 32'(count), 0);
      check("reset_dout_valid", 32'(dout_valid), 0);
      check("reset_din_ready", 32'(din_ready), 1);
`ifdef ALMOST_FLAGS_EN
      check("reset_almost_empty", 32'(almost_empty), 1);
      check("reset_almost_full", 32'(almost_full), 0);
`endif

      // 2 Fill with words 1..12, then attempt a fifth push.
      for (int k = 0; k < 4; k++) begin
         cycle(1'b1, 3*k + 1, 1'b0, 1'b0, 1'b1);
         check("fill_count", 32'(count), 32'(3*(k + 1)));
      end
      check("full_din_ready", 32'(din_ready), 0);
      check("full_dout_head", 32'(dout), {16'd2, 16'd1});
      cycle(1'b1, 13, 1'b0, 1'b0, 1'b0);
      check("full_push_ignored", 32'(count), 12);

      // 3 Drain with six pops, then a seventh pop attempt.
      for (int k = 0; k < 6; k++) begin
         cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
         check("drain_count", 32'(count), 32'(12 - 2*(k + 1)));
      end
      check("empty_dout_valid", 32'(dout_valid), 0);
      cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
      check("empty_pop_ignored", 32'(count), 0);

      // 4 Wrap: refill, pop two pairs, then push 13..15 into addresses 0..2.
      for (int k = 0; k < 4; k++) cycle(1'b1, 3*k + 1, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
      check("wrap_count8", 32'(count), 8);
      cycle(1'b1, 13, 1'b0, 1'b0, 1'b1);
      check("wrap_count11", 32'(count), 11);
      check("wrap_din_ready", 32'(din_ready), 0);
`ifdef ALMOST_FLAGS_EN
      check("wrap_almost_full", 32'(almost_full), 1);
`endif
      for (int k = 0; k < 5; k++) cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
      check("wrap_leftover_count", 32'(count), 1);
      check("wrap_leftover_valid", 32'(dout_valid), 0);

      // Reset again so the next phase starts from empty pointers.
      rst = 1'b0;
      @(posedge clk);
      exp_q.delete();
      #1;
      rst = 1'b1;
      check("rereset_count", 32'(count), 0);

      // 5 Simultaneous push and pop.
      cycle(1'b1, 16, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 19, 1'b0, 1'b0, 1'b1);
      check("sim_count6", 32'(count), 6);
      cycle(1'b1, 22, 1'b1, 1'b0, 1'b1);
      check("sim_count7", 32'(count), 7);
      cycle(1'b1, 25, 1'b0, 1'b0, 1'b1);
      check("sim_count10", 32'(count), 10);
      check("sim_din_ready10", 32'(din_ready), 0);
      cycle(1'b1, 28, 1'b1, 1'b0, 1'b0);
      check("sim_blocked_push", 32'(count), 8);
      cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 28, 1'b0, 1'b0, 1'b1);
      check("sim_count9", 32'(count), 9);

      // 6 Flush together with a push: both pointers clear and the push is dropped.
      cycle(1'b1, 31, 1'b0, 1'b1, 1'b0);
      check("flush_count", 32'(count), 0);
      check("flush_dout_valid", 32'(dout_valid), 0);
      check("flush_din_ready", 32'(din_ready), 1);
`ifdef ALMOST_FLAGS_EN
      check("flush_almost_empty", 32'(almost_empty), 1);
      check("flush_almost_full", 32'(almost_full), 0);
`endif
      cycle(1'b1, 34, 1'b0, 1'b0, 1'b1);
      check("post_flush_head", 32'(dout), {16'd35, 16'd34});
      cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
      check("post_flush_count", 32'(count), 1);

      repeat (2) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
